// File: rtl/voxel_scene_walker.sv
// Walks a GRID_X*GRID_Y*GRID_Z occupancy BRAM in x-fastest order and issues one cube draw per set voxel.
// Define WALKER_ABORT_EN to add an abort input that ends the walk early (after any draw in flight).
module voxel_scene_walker #(
  parameter int                     COORD_WIDTH = 32,
  parameter int                     GRID_X      = 8,
  parameter int                     GRID_Y      = 8,
  parameter int                     GRID_Z      = 8,
  parameter logic [COORD_WIDTH-1:0] CUBE_WIDTH  = COORD_WIDTH'(32'h0001_0000),
  parameter int                     OCC_LATENCY = 2,
  parameter int                     ADDR_WIDTH  = $clog2(GRID_X*GRID_Y*GRID_Z)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic signed [COORD_WIDTH-1:0] origin_x,
  input  logic signed [COORD_WIDTH-1:0] origin_y,
  input  logic signed [COORD_WIDTH-1:0] origin_z,
  output logic        [ADDR_WIDTH-1:0]  occ_addr,
  input  logic                          occ_data,
  output logic                          cube_start,
  output logic signed [COORD_WIDTH-1:0] x_corner,
  output logic signed [COORD_WIDTH-1:0] y_corner,
  output logic signed [COORD_WIDTH-1:0] z_corner,
  input  logic                          cube_done,
  output logic        [ADDR_WIDTH:0]    cube_count,
  output logic                          busy,
  output logic                          done
`ifdef WALKER_ABORT_EN
  ,
  input  logic                          abort
`endif
);
  localparam int XW = (GRID_X > 1) ? $clog2(GRID_X) : 1;
  localparam int YW = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;
  localparam int ZW = (GRID_Z > 1) ? $clog2(GRID_Z) : 1;
  localparam int WW = (OCC_LATENCY > 1) ? $clog2(OCC_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_WAIT_CUBE, S_ADVANCE, S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [XW-1:0]            ix;
  logic [YW-1:0]            iy;
  logic [ZW-1:0]            iz;
  logic [WW-1:0]            wcnt;
  logic signed [COORD_WIDTH-1:0] org_x, org_y;
  logic                     x_last, y_last, last_vox;
  logic                     abort_now, abort_hold;

  assign x_last   = (ix == XW'(GRID_X-1));
  assign y_last   = (iy == YW'(GRID_Y-1));
  assign last_vox = x_last && y_last && (iz == ZW'(GRID_Z-1));

`ifdef WALKER_ABORT_EN
  // An abort seen while a draw is in flight is remembered until cube_done.
  assign abort_now = abort;
  always_ff @(posedge clk_in) begin
    if (rst_in)                                abort_hold <= 1'b0;
    else if (state == S_IDLE && start)         abort_hold <= 1'b0;
    else if (state == S_WAIT_CUBE && abort)    abort_hold <= 1'b1;
  end
`else
  assign abort_now  = 1'b0;
  assign abort_hold = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH;
      S_FETCH:     state_nxt = (OCC_LATENCY == 1) ? S_CHECK : S_WAIT;
      S_WAIT:      if (wcnt == WW'(OCC_LATENCY-1)) state_nxt = S_CHECK;
      S_CHECK:     state_nxt = occ_data ? S_WAIT_CUBE : S_ADVANCE;
      // cube_done coinciding with our own cube_start belongs to nothing we issued
      S_WAIT_CUBE: if (cube_done && !cube_start)
                     state_nxt = (abort_now || abort_hold) ? S_DONE : S_ADVANCE;
      S_ADVANCE:   state_nxt = last_vox ? S_DONE : S_FETCH;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (abort_now && (state == S_FETCH || state == S_WAIT ||
                      state == S_CHECK || state == S_ADVANCE))
      state_nxt = S_DONE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ix <= '0; iy <= '0; iz <= '0; wcnt <= '0;
      occ_addr <= '0; cube_count <= '0;
      org_x <= '0; org_y <= '0;
      x_corner <= '0; y_corner <= '0; z_corner <= '0;
      cube_start <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      cube_start <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          org_x <= origin_x; org_y <= origin_y;
          x_corner <= origin_x; y_corner <= origin_y; z_corner <= origin_z;
          ix <= '0; iy <= '0; iz <= '0;
          occ_addr <= '0; cube_count <= '0;
          busy <= 1'b1;
        end
        S_FETCH: wcnt <= WW'(1);
        S_WAIT:  wcnt <= wcnt + 1'b1;
        S_CHECK: if (state_nxt == S_WAIT_CUBE) begin
          cube_start <= 1'b1;
          cube_count <= cube_count + 1'b1;
        end
        // Address is linear in traversal order, so it just counts; corners accumulate per axis.
        S_ADVANCE: if (state_nxt == S_FETCH) begin
          occ_addr <= occ_addr + 1'b1;
          if (x_last) begin
            ix <= '0; x_corner <= org_x;
            if (y_last) begin
              iy <= '0; y_corner <= org_y;
              iz <= iz + 1'b1; z_corner <= z_corner + CUBE_WIDTH;
            end else begin
              iy <= iy + 1'b1; y_corner <= y_corner + CUBE_WIDTH;
            end
          end else begin
            ix <= ix + 1'b1; x_corner <= x_corner + CUBE_WIDTH;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voxel_scene_walker.sv
// Randomized bench for voxel_scene_walker: an 8x8x8/latency-2 instance and a 2x2x2/latency-1 instance
// checked against a per-walk expected list of draws and a closed-form completion time.
module tb_voxel_scene_walker;
  localparam logic [31:0] CW = 32'h0001_0000;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, start, cube_done, abort, sel;
  logic signed [31:0] org_x, org_y, org_z;
  logic occ_mem [512];

  logic [8:0] addr_a;  logic [2:0] addr_b;
  logic [9:0] cnt_a;   logic [3:0] cnt_b;
  logic cs_a, cs_b, busy_a, busy_b, done_a, done_b;
  logic signed [31:0] xa, ya, za, xb, yb, zb;
  logic [1:0] pipe_a;  logic pipe_b;
  logic start_a, start_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  // Occupancy BRAMs: 2-cycle and 1-cycle read latency over the same bit array.
  always @(posedge clk_in) begin
    pipe_a <= {pipe_a[0], occ_mem[addr_a]};
    pipe_b <= occ_mem[{6'd0, addr_b}];
  end

  voxel_scene_walker #(.GRID_X(8), .GRID_Y(8), .GRID_Z(8), .OCC_LATENCY(2)) u_a (
    .clk_in(clk_in), .rst_in(rst_in), .start(start_a),
    .origin_x(org_x), .origin_y(org_y), .origin_z(org_z),
    .occ_addr(addr_a), .occ_data(pipe_a[1]), .cube_start(cs_a),
    .x_corner(xa), .y_corner(ya), .z_corner(za), .cube_done(cube_done),
    .cube_count(cnt_a), .busy(busy_a), .done(done_a)
`ifdef WALKER_ABORT_EN
    , .abort(abort & ~sel)
`endif
  );

  voxel_scene_walker #(.GRID_X(2), .GRID_Y(2), .GRID_Z(2), .OCC_LATENCY(1)) u_b (
    .clk_in(clk_in), .rst_in(rst_in), .start(start_b),
    .origin_x(org_x), .origin_y(org_y), .origin_z(org_z),
    .occ_addr(addr_b), .occ_data(pipe_b), .cube_start(cs_b),
    .x_corner(xb), .y_corner(yb), .z_corner(zb), .cube_done(cube_done),
    .cube_count(cnt_b), .busy(busy_b), .done(done_b)
`ifdef WALKER_ABORT_EN
    , .abort(abort & sel)
`endif
  );

  logic [9:0] addr_m, cnt_m;
  logic cs_m, busy_m, done_m;
  logic [31:0] xm, ym, zm;
  assign addr_m = sel ? {7'd0, addr_b} : {1'b0, addr_a};
  assign cnt_m  = sel ? {6'd0, cnt_b}  : cnt_a;
  assign cs_m   = sel ? cs_b   : cs_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign xm = sel ? xb : xa;
  assign ym = sel ? yb : ya;
  assign zm = sel ? zb : za;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic fill(input int pct);
    for (int i = 0; i < 512; i++) occ_mem[i] = ($urandom_range(99) < pct);
  endtask

  // One walk: the model lists every occupied voxel in x-fastest order with corner = origin + index*CW.
  task automatic run_walk(input logic s, input int dlat, input logic spur,
                          input logic [31:0] ox, input logic [31:0] oy, input logic [31:0] oz,
                          input int rst_at, input int abort_at);
    int gx, gy, gz, lat, expk, expn, k, dcnt, ncs;
    logic got;
    logic [31:0] qa[$], qx[$], qy[$], qz[$];
    logic [31:0] hx, hy, hz;
    gx = s ? 2 : 8; gy = gx; gz = gx; lat = s ? 1 : 2;
    for (int z = 0; z < gz; z++)
      for (int y = 0; y < gy; y++)
        for (int x = 0; x < gx; x++)
          if (occ_mem[x + gx*(y + gy*z)]) begin
            qa.push_back(32'(x + gx*(y + gy*z)));
            qx.push_back(ox + 32'(x) * CW);
            qy.push_back(oy + 32'(y) * CW);
            qz.push_back(oz + 32'(z) * CW);
          end
    expn = qa.size();
    expk = 1 + gx*gy*gz*(lat + 2) + expn*(1 + dlat);
    hx = '0; hy = '0; hz = '0;
    @(negedge clk_in);
    sel = s; org_x = ox; org_y = oy; org_z = oz; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0; k = 0; dcnt = 0; ncs = 0; got = 1'b0;
    chk("busy_after_start", 32'(busy_m), 32'd1);
    while (!got && k <= expk + 40) begin
      cube_done = 1'b0; start = 1'b0; abort = 1'b0;
      if (done_m) begin
        got = 1'b1;
        chk("done_cycle", 32'(k), 32'(expk));
        chk("cube_count", 32'(cnt_m), 32'(expn));
        chk("busy_at_done", 32'(busy_m), 32'd0);
        chk("num_starts", 32'(ncs), 32'(expn));
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            cube_done = 1'b1;
            chk("x_hold", xm, hx); chk("y_hold", ym, hy); chk("z_hold", zm, hz);
          end
        end
        if (cs_m) begin
          ncs++;
          if (qa.size() == 0) chk("extra_start", 32'(ncs), 32'(expn));
          else begin
            chk("occ_addr", 32'(addr_m), qa.pop_front());
            hx = qx.pop_front(); hy = qy.pop_front(); hz = qz.pop_front();
            chk("x_corner", xm, hx); chk("y_corner", ym, hy); chk("z_corner", zm, hz);
          end
          dcnt = dlat;
          if (spur && $urandom_range(1) == 1) cube_done = 1'b1;
          if (ncs == rst_at) begin
            rst_in = 1'b1;
            @(negedge clk_in);
            chk("rst_busy", 32'(busy_m), 32'd0);
            chk("rst_cube_start", 32'(cs_m), 32'd0);
            chk("rst_cube_count", 32'(cnt_m), 32'd0);
            chk("rst_occ_addr", 32'(addr_m), 32'd0);
            chk("rst_x_corner", xm, 32'd0);
            rst_in = 1'b0; cube_done = 1'b0;
            @(negedge clk_in);
            chk("rst_no_done", 32'(done_m), 32'd0);
            return;
          end
          if (ncs == abort_at) begin
            abort = 1'b1; expk = k + dlat + 2; expn = ncs;
          end
        end else if (spur && dcnt == 0 && $urandom_range(7) == 0) cube_done = 1'b1;
        if (spur && $urandom_range(15) == 0) start = 1'b1;
        @(negedge clk_in);
        k++;
      end
    end
    if (!got) chk("done_seen", 32'(got), 32'd1);
    cube_done = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk_in);
    chk("done_one_cycle", 32'(done_m), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; start = 1'b0; cube_done = 1'b0; abort = 1'b0; sel = 1'b0;
    org_x = '0; org_y = '0; org_z = '0;
    fill(0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("reset_busy_a", 32'(busy_a), 32'd0);
    chk("reset_done_a", 32'(done_a), 32'd0);
    chk("reset_cs_a", 32'(cs_a), 32'd0);
    chk("reset_count_a", 32'(cnt_a), 32'd0);
    chk("reset_addr_a", 32'(addr_a), 32'd0);
    chk("reset_corner_a", xa ^ ya ^ za, 32'd0);
    chk("reset_busy_b", 32'(busy_b), 32'd0);
    chk("reset_count_b", 32'(cnt_b), 32'd0);

    // empty 8x8x8 grid with spurious start / cube_done noise
    run_walk(1'b0, 3, 1'b1, $urandom, $urandom, $urandom, -1, -1);
    // single voxel (1,2,3) at origin 0
    fill(0); occ_mem[209] = 1'b1;
    run_walk(1'b0, 5, 1'b0, 32'd0, 32'd0, 32'd0, -1, -1);
    // full 2x2x2, origin (-1.0, 0, 0), 20-cycle drawer
    fill(100);
    run_walk(1'b1, 20, 1'b0, 32'hFFFF_0000, 32'd0, 32'd0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      fill(8);
      run_walk(1'b0, $urandom_range(6, 1), 1'b1, $urandom, $urandom, $urandom, -1, -1);
    end
    for (int i = 0; i < 4; i++) begin
      fill(50);
      run_walk(1'b1, $urandom_range(4, 1), 1'b1, $urandom, $urandom, $urandom, -1, -1);
    end
    // reset during a draw, then a fresh walk must restart from voxel 0
    fill(100);
    run_walk(1'b0, 6, 1'b0, 32'h0003_0000, 32'd0, 32'hFFFE_0000, 2, -1);
    fill(10);
    run_walk(1'b0, 2, 1'b0, 32'h0010_8000, 32'h8000_0000, 32'd0, -1, -1);
`ifdef WALKER_ABORT_EN
    fill(100);
    run_walk(1'b0, 3, 1'b0, 32'd0, 32'd0, 32'd0, -1, 3);
    fill(30);
    run_walk(1'b1, 2, 1'b0, 32'd0, 32'd0, 32'd0, -1, 2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
